// File: rtl/fetch_sequencer.sv
// Byte fetch sequencer: credit-limited memory reads, in-flight tracking and a head-presented queue.
// Optional FETCH_SKIP_ZERO_PAD_EN drops leading 0x00 bytes after each start.
module fetch_sequencer #(
  parameter int unsigned       LOAD_LATENCY = 1,
  parameter int unsigned       QDEPTH       = 4,
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              flush_out,
  output logic [1:0]        state_o
);

  localparam int unsigned PtrW = $clog2(QDEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StHalted = 2'd2} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         fetch_pc_q, fetch_pc_d;
  logic [LOAD_LATENCY-1:0]   slot_vld_q, slot_vld_d;
  logic [ADDR_W-1:0]         slot_pc_q [LOAD_LATENCY];
  logic [ADDR_W-1:0]         slot_pc_d [LOAD_LATENCY];
  logic [7:0]                q_data_q [QDEPTH];
  logic [ADDR_W-1:0]         q_pc_q [QDEPTH];
  logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]           count_q, count_d;
  logic                      flush_q, flush_d;

  logic                      redir, start_edge, credit, issue, emerge, enq, pop, drop_zero;
  int unsigned               inflight;

  always_comb begin
    redir      = redirect && (state_q != StIdle);
    start_edge = start && (state_q == StIdle);

    inflight = 0;
    for (int i = 0; i < LOAD_LATENCY; i++) inflight += 32'(slot_vld_q[i]);
    credit = (32'(count_q) + inflight) < QDEPTH;

    issue  = (state_q == StRun) && !halt && !redir && credit && !rst;
    emerge = slot_vld_q[LOAD_LATENCY-1];
    enq    = emerge && !redir && !drop_zero;
    pop    = (count_q != '0) && out_ready && !redir;

    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StRun;
      StRun:    if (halt && !redir) state_d = StHalted;
      StHalted: if (!halt && !redir) state_d = StRun;
      default:  state_d = StIdle;
    endcase

    fetch_pc_d = fetch_pc_q;
    if (start_edge)  fetch_pc_d = RESET_PC;
    else if (redir)  fetch_pc_d = redirect_pc;
    else if (issue)  fetch_pc_d = fetch_pc_q + ADDR_W'(1);

    slot_vld_d    = '0;
    slot_vld_d[0] = issue;
    slot_pc_d[0]  = fetch_pc_q;
    for (int i = 1; i < LOAD_LATENCY; i++) begin
      slot_vld_d[i] = slot_vld_q[i-1];
      slot_pc_d[i]  = slot_pc_q[i-1];
    end

    wr_ptr_d = wr_ptr_q + PtrW'(enq);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(enq) - CntW'(pop);
    if (redir || start_edge) begin
      slot_vld_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end

    flush_d = redir;
  end

`ifdef FETCH_SKIP_ZERO_PAD_EN
  logic skip_q, skip_d;

  always_comb begin
    drop_zero = skip_q && (mem_data == 8'h00);
    skip_d    = skip_q;
    if (start_edge)                                  skip_d = 1'b1;
    else if (emerge && !redir && mem_data != 8'h00) skip_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) skip_q <= 1'b0;
    else     skip_q <= skip_d;
  end
`else
  assign drop_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      slot_vld_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      slot_vld_q <= slot_vld_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
    end
  end

  // Payload storage needs no reset; validity lives in slot_vld_q and count_q.
  always_ff @(posedge clk) begin
    slot_pc_q <= slot_pc_d;
    if (enq) begin
      q_data_q[wr_ptr_q] <= mem_data;
      q_pc_q[wr_ptr_q]   <= slot_pc_q[LOAD_LATENCY-1];
    end
  end

  // Outputs are forced to their reset values for the whole time rst is high.
  always_comb begin
    mem_rd_en = issue;
    mem_addr  = rst ? RESET_PC : fetch_pc_q;
    out_valid = (count_q != '0) && !rst;
    out_inst  = out_valid ? q_data_q[rd_ptr_q] : 8'h00;
    out_pc    = out_valid ? q_pc_q[rd_ptr_q] : '0;
    flush_out = flush_q && !rst;
    state_o   = rst ? StIdle : state_q;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter LOAD_LATENCY, default 1: cycles from mem_rd_en to mem_data valid, legal 1..4.
REQ-002 SHALL have parameter QDEPTH, default 4: byte queue entries, power of two, 2..16.
REQ-003 SHALL have parameter ADDR_W, default 32: address width.
REQ-004 SHALL have parameter RESET_PC, default 0: first fetch address after start.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit: a one-cycle pulse that leaves IDLE.
REQ-008 SHALL have port halt, input, 1 bit: level input that stops new reads.
REQ-009 SHALL have port redirect, input, 1 bit: branch/exception redirect request.
REQ-010 SHALL have port redirect_pc, input, ADDR_W bits: the new fetch address.
REQ-011 SHALL have port mem_rd_en, output, 1 bit: byte read request.
REQ-012 SHALL have port mem_addr, output, ADDR_W bits: byte read address.
REQ-013 SHALL have port mem_data, input, 8 bits: read byte, valid LOAD_LATENCY cycles after its request.
REQ-014 SHALL have port out_valid, output, 1 bit: a byte is presented to the fetch phase.
REQ-015 SHALL have port out_ready, input, 1 bit: the fetch phase consumes this cycle (its ~stall).
REQ-016 SHALL have port out_inst, output, 8 bits: the presented byte.
REQ-017 SHALL have port out_pc, output, ADDR_W bits: the address of out_inst.
REQ-018 SHALL have port flush_out, output, 1 bit: one-cycle flush to the fetch phase decoder.
REQ-019 SHALL have port state_o, output, 2 bits: current state (IDLE=0, RUN=1, HALTED=2).

Function
REQ-020 SHALL implement FSM IDLE->RUN on start, RUN->HALTED on halt, HALTED->RUN on halt deasserted; start is ignored outside IDLE.
REQ-021 SHALL, on the IDLE->RUN edge, load fetch_pc with RESET_PC and clear the queue.
REQ-022 SHALL assert mem_rd_en with mem_addr=fetch_pc only in RUN, only when queue occupancy + in-flight count < QDEPTH, and never in a redirect cycle; each issue increments fetch_pc by 1, wrapping modulo 2^ADDR_W.
REQ-023 SHALL track in-flight reads with a LOAD_LATENCY-deep valid/pc shift register, and enqueue {mem_data, pc} when the tagged slot emerges.
REQ-024 SHALL present the queue head combinationally: out_valid = queue not empty; a pop occurs when out_valid&out_ready.
REQ-025 SHALL support enqueue and pop in the same cycle with occupancy unchanged, including when full; the credit rule of REQ-022 guarantees no overflow.
REQ-026 SHALL, on redirect (in RUN or HALTED), in the same cycle: clear the queue, invalidate all in-flight slots, set fetch_pc=redirect_pc, suppress issue and pop, and register flush_out=1 for the following cycle only.
REQ-027 SHALL give redirect priority over halt, enqueue, pop and issue in the same cycle; a redirect in IDLE is ignored.
REQ-028 SHALL, with redirect at cycle t, issue from redirect_pc at t+1, and present the first byte no earlier than t+1+LOAD_LATENCY.
REQ-029 SHALL let in-flight reads complete, and the queue drain, while HALTED.
REQ-030 SHALL hold out_inst/out_pc stable while out_valid&~out_ready.

Reset
REQ-031 SHALL, while rst=1: set state=IDLE, fetch_pc=RESET_PC, queue empty, all in-flight slots invalid, and mem_rd_en=0, out_valid=0, flush_out=0, mem_addr=RESET_PC, out_inst=0, out_pc=0.
REQ-032 SHALL let rst asserted mid-operation override every other input in that cycle; bytes returning after reset SHALL be discarded.

Configuration
REQ-033 SHALL, with FETCH_SKIP_ZERO_PAD_EN defined, discard 0x00 bytes returned after IDLE->RUN until the first nonzero byte, which is enqueued and ends skipping until the next start; a discarded byte SHALL return its credit.
REQ-034 SHALL, without FETCH_SKIP_ZERO_PAD_EN, enqueue every returned byte.

Verification
REQ-035 SHALL cover: reset, start, memory bytes 0x48,0x89,0xC3, out_ready=1 -> pcs 0,1,2 presented in order, first byte at cycle start+1+LOAD_LATENCY+1.
REQ-036 SHALL cover: out_ready=0 for 10 cycles, QDEPTH=4 -> exactly 4 reads issued, out_pc=0 held, no read issued while full.
REQ-037 SHALL cover: redirect with redirect_pc=0x100 while 2 reads are in flight -> stale bytes dropped, flush_out high exactly 1 cycle, next out_pc=0x100.
REQ-038 SHALL cover: halt held 5 cycles -> mem_rd_en=0 throughout, queue drains, issue resumes at the next sequential pc.
REQ-039 SHALL cover: with FETCH_SKIP_ZERO_PAD_EN, memory 0x00,0x00,0x55,0x00 -> first out_inst=0x55 with out_pc=2, followed by 0x00 with out_pc=3.
REQ-040 SHALL cover: fetch_pc=2^ADDR_W-1 -> the next issue uses mem_addr=0.
